bram_fifo_ctrl: RTL and testbench

Synchronous FIFO controller that wraps the true dual-port block RAM (`bram_true_dual_port`) and turns it into a streaming buffer. It sits directly upstream of the RAM instance: port A is driven as the write port and port B as the read port. The user sees valid/ready streams on both sides. A 2-entry output buffer hides the RAM's 1-cycle read latency, so the FIFO is first-word-fall-through and sustains one word per cycle.

---
 rtl/bram_fifo_ctrl.sv | 135 +++++++++++++
 tb/tb_bram_fifo_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_fifo_ctrl.sv
// FWFT stream FIFO over a true dual-port BRAM (A = write, B = read); 2-entry output buffer hides read latency.
// Optional almost_full/almost_empty flags are enabled by defining BRAM_FIFO_ALMOST_FLAGS_EN.
module bram_fifo_ctrl #(
    parameter int RAM_WIDTH = 16,
    parameter int RAM_DEPTH = 1024
`ifdef BRAM_FIFO_ALMOST_FLAGS_EN
    ,
    parameter int AFULL_TH  = RAM_DEPTH - 4,
    parameter int AEMPTY_TH = 4
`endif
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [RAM_WIDTH-1:0]           s_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [RAM_WIDTH-1:0]           m_data,
    output logic [$clog2(RAM_DEPTH+3)-1:0] level,
    output logic                           wr_ena,
    output logic [$clog2(RAM_DEPTH)-1:0]   addra,
    output logic [RAM_WIDTH-1:0]           dina,
    output logic                           rd_ena,
    output logic                           wr_enb,
    output logic [RAM_WIDTH-1:0]           dinb,
    output logic                           rd_enb,
    output logic [$clog2(RAM_DEPTH)-1:0]   addrb,
    input  logic [RAM_WIDTH-1:0]           doutb
`ifdef BRAM_FIFO_ALMOST_FLAGS_EN
    ,
    output logic                           almost_full,
    output logic                           almost_empty
`endif
);

    localparam int AW = $clog2(RAM_DEPTH);
    localparam int LW = $clog2(RAM_DEPTH + 3);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(RAM_DEPTH);

    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          bram_cnt;
    logic                 inflight;
    logic                 out_valid;
    logic                 skid_valid;
    logic [RAM_WIDTH-1:0] out_data;
    logic [RAM_WIDTH-1:0] skid_data;

    logic                 wr_acc;
    logic                 pop;
    logic                 issue;
    logic [1:0]           occ;

    assign s_ready = !rst && (bram_cnt < DEPTH_C);
    assign wr_acc  = s_valid && s_ready;
    assign pop     = out_valid && m_ready;

    // Words already owned by the output stage, counting the one the RAM is returning.
    assign occ   = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, inflight};
    assign issue = !rst && (bram_cnt != '0) && (occ < (2'd2 + {1'b0, pop}));

    assign wr_ena = wr_acc;
    assign addra  = wr_ptr;
    assign dina   = s_data;
    assign rd_enb = issue;
    assign addrb  = rd_ptr;
    assign rd_ena = 1'b0;
    assign wr_enb = 1'b0;
    assign dinb   = '0;

    assign m_valid = out_valid;
    assign m_data  = out_data;
    assign level   = LW'(bram_cnt) + LW'(inflight) + LW'(out_valid) + LW'(skid_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            bram_cnt   <= '0;
            inflight   <= 1'b0;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_data   <= '0;
            skid_data  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (issue)  rd_ptr <= rd_ptr + 1'b1;

            case ({wr_acc, issue})
                2'b10:   bram_cnt <= bram_cnt + 1'b1;
                2'b01:   bram_cnt <= bram_cnt - 1'b1;
                default: bram_cnt <= bram_cnt;
            endcase

            inflight <= issue;

            if (pop) begin
                if (skid_valid) begin
                    out_data   <= skid_data;
                    skid_valid <= inflight;
                    if (inflight) skid_data <= doutb;
                end else if (inflight) begin
                    out_data <= doutb;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (inflight) begin
                if (!out_valid) begin
                    out_valid <= 1'b1;
                    out_data  <= doutb;
                end else begin
                    skid_valid <= 1'b1;
                    skid_data  <= doutb;
                end
            end
        end
    end

`ifdef BRAM_FIFO_ALMOST_FLAGS_EN
    localparam logic [LW-1:0] AFULL_C  = LW'(AFULL_TH);
    localparam logic [LW-1:0] AEMPTY_C = LW'(AEMPTY_TH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (level >= AFULL_C);
            almost_empty <= (level <= AEMPTY_C);
        end
    end
`endif

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Scoreboarded bench for bram_fifo_ctrl with a behavioural BRAM and queue-based reference model.
module tb_bram_fifo_ctrl;

    localparam int W  = 16;
    localparam int D  = 16;
    localparam int AW = 4;
    localparam int LW = 5;
    localparam int AF = 12;
    localparam int AE = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [W-1:0]  s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [W-1:0]  m_data;
    logic [LW-1:0] level;
    logic          wr_ena;
    logic [AW-1:0] addra;
    logic [W-1:0]  dina;
    logic          rd_ena;
    logic          wr_enb;
    logic [W-1:0]  dinb;
    logic          rd_enb;
    logic [AW-1:0] addrb;
    logic [W-1:0]  doutb;
`ifdef BRAM_FIFO_ALMOST_FLAGS_EN
    logic          almost_full;
    logic          almost_empty;
`endif

    always #5 clk = ~clk;

    bram_fifo_ctrl #(
        .RAM_WIDTH(W),
        .RAM_DEPTH(D)
`ifdef BRAM_FIFO_ALMOST_FLAGS_EN
        ,
        .AFULL_TH (AF),
        .AEMPTY_TH(AE)
`endif
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .level   (level),
        .wr_ena  (wr_ena),
        .addra   (addra),
        .dina    (dina),
        .rd_ena  (rd_ena),
        .wr_enb  (wr_enb),
        .dinb    (dinb),
        .rd_enb  (rd_enb),
        .addrb   (addrb),
        .doutb   (doutb)
`ifdef BRAM_FIFO_ALMOST_FLAGS_EN
        ,
        .almost_full (almost_full),
        .almost_empty(almost_empty)
`endif
    );

    // Behavioural true dual-port RAM: registered read on port B, contents survive reset.
    logic [W-1:0] mem [D];
    always @(posedge clk) begin
        if (wr_ena) mem[addra] <= dina;
        if (rd_enb) doutb <= mem[addrb];
    end

    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] exp_q [$];
    int           mdl_cnt = 0;
    int           wa = 0;
    int           ra = 0;
    int           pops_total = 0;
    int           prev_level = 0;
    bit           stream_mode = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: model is "accepted words minus delivered words", in order.
    always @(negedge clk) begin
        if (rst) begin
            mdl_cnt    = 0;
            wa         = 0;
            ra         = 0;
            prev_level = 0;
            exp_q.delete();
        end else begin
            chk("level", 32'(level), mdl_cnt);
            if (mdl_cnt < D)      chk("s_ready_room", 32'(s_ready), 1);
            if (mdl_cnt == D + 2) chk("s_ready_full", 32'(s_ready), 0);
            chk("wr_ena", 32'(wr_ena), 32'(s_valid & s_ready));
            if (wr_ena) begin
                chk("addra", 32'(addra), wa % D);
                chk("dina", 32'(dina), 32'(s_data));
            end
            if (rd_enb) begin
                chk("addrb", 32'(addrb), ra % D);
                ra++;
            end
            chk("tied_zero", {31'd0, rd_ena | wr_enb | (|dinb)}, 0);
            if (stream_mode) chk("stream_level_max3", 32'(level <= 3), 1);
`ifdef BRAM_FIFO_ALMOST_FLAGS_EN
            chk("almost_full", 32'(almost_full), 32'(prev_level >= AF));
            chk("almost_empty", 32'(almost_empty), 32'(prev_level <= AE));
`endif
            if (exp_q.size() == 0) begin
                chk("m_valid_when_empty", 32'(m_valid), 0);
            end else if (m_valid && m_ready) begin
                chk("m_data", 32'(m_data), 32'(exp_q.pop_front()));
                pops_total++;
                mdl_cnt--;
            end
            if (s_valid && s_ready) begin
                exp_q.push_back(s_data);
                wa++;
                mdl_cnt++;
            end
            prev_level = int'(level);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready), 0);
        chk({tag, "_m_valid"}, 32'(m_valid), 0);
        chk({tag, "_level"},   32'(level),   0);
        chk({tag, "_wr_ena"},  32'(wr_ena),  0);
        chk({tag, "_rd_enb"},  32'(rd_enb),  0);
        chk({tag, "_addra"},   32'(addra),   0);
        chk({tag, "_addrb"},   32'(addrb),   0);
`ifdef BRAM_FIFO_ALMOST_FLAGS_EN
        chk({tag, "_almost_full"},  32'(almost_full),  0);
        chk({tag, "_almost_empty"}, 32'(almost_empty), 1);
`endif
    endtask

    initial begin
        int n;
        int cyc;
        int p0;

        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("s_ready_after_rst", 32'(s_ready), 1);

        // Single write, latency to the output.
        tick();
        s_valid = 1'b1;
        s_data  = 16'habcd;
        @(negedge clk);
        chk("t1_wr_ena", 32'(wr_ena), 1);
        chk("t1_addra", 32'(addra), 0);
        tick();
        s_valid = 1'b0;
        @(negedge clk);
        chk("t1_rd_enb_e1", 32'(rd_enb), 1);
        chk("t1_m_valid_e1", 32'(m_valid), 0);
        tick();
        @(negedge clk);
        chk("t1_m_valid_e2", 32'(m_valid), 0);
        tick();
        @(negedge clk);
        chk("t1_m_valid_e3", 32'(m_valid), 1);
        chk("t1_m_data", 32'(m_data), 32'h0000abcd);
        chk("t1_level", 32'(level), 1);
        tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        repeat (2) tick();

        // Full-rate stream of 0..99.
        p0 = pops_total;
        stream_mode = 1'b1;
        s_valid = 1'b1;
        m_ready = 1'b1;
        s_data  = '0;
        n = 0;
        cyc = 0;
        while (n < 100 && cyc < 200) begin
            @(negedge clk);
            if (s_ready) n++;
            tick();
            s_data = W'(n);
            cyc++;
        end
        s_valid = 1'b0;
        chk("stream_accept_cycles", cyc, 100);
        cyc = 0;
        while (level != 0 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("stream_drain_cycles", cyc, 3);
        chk("stream_pops", pops_total - p0, 100);
        stream_mode = 1'b0;
        m_ready = 1'b0;
        tick();

        // Fill to capacity with the consumer stalled, then drain.
        p0 = pops_total;
        s_valid = 1'b1;
        n = 0;
        for (int c = 0; c < 25; c++) begin
            s_data = W'($urandom);
            @(negedge clk);
            if (s_ready) n++;
            tick();
        end
        s_valid = 1'b0;
        chk("fill_accepts", n, D + 2);
        @(negedge clk);
        chk("fill_level", 32'(level), D + 2);
        chk("fill_s_ready", 32'(s_ready), 0);
        tick();
        m_ready = 1'b1;
        repeat (30) tick();
        m_ready = 1'b0;
        chk("fill_drain_pops", pops_total - p0, D + 2);

        // Random gaps on both sides across several pointer wraps.
        p0 = pops_total;
        n = 0;
        for (int c = 0; c < 400 && (n < 40 || pops_total - p0 < 40); c++) begin
            s_valid = (n < 40) && ($urandom_range(0, 2) != 0);
            s_data  = W'($urandom);
            m_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            if (s_valid && s_ready) n++;
            tick();
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        chk("wrap_pops", pops_total - p0, 40);

        // Reset while 7 words are held and a read is in flight.
        tick();
        s_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            s_data = W'($urandom);
            tick();
        end
        s_valid = 1'b0;
        repeat (4) tick();
        m_ready = 1'b1;
        @(negedge clk);
        chk("mid_rd_enb", 32'(rd_enb), 1);
        chk("mid_level8", 32'(level), 8);
        tick();
        chk("mid_level7", 32'(level), 7);
        m_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        repeat (2) tick();
        rst = 1'b0;
        tick();
        p0 = pops_total;
        s_valid = 1'b1;
        s_data  = 16'h5a5a;
        @(negedge clk);
        chk("post_rst_addra", 32'(addra), 0);
        chk("post_rst_wr_ena", 32'(wr_ena), 1);
        tick();
        s_valid = 1'b0;
        m_ready = 1'b1;
        cyc = 0;
        while (pops_total == p0 && cyc < 10) begin
            tick();
            cyc++;
        end
        chk("post_rst_first_out", pops_total - p0, 1);
        m_ready = 1'b0;
        tick();

        // Level ramp through both flag thresholds, then drain.
        s_valid = 1'b1;
        for (int c = 0; c < 14; c++) begin
            s_data = W'($urandom);
            tick();
        end
        s_valid = 1'b0;
        repeat (3) tick();
        m_ready = 1'b1;
        repeat (20) tick();
        m_ready = 1'b0;
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
